// File: rtl/wash_panel_ctrl.sv
// Washer front-panel controller.
// Debounces the program/start buttons, holds the program selection, issues
// the one-cycle start request, locks the door during a run, counts run time
// in ticks and drives the buzzer for errors, faults, soap and end of program.
//
// Start interface to the washer FSM: start is a registered single-cycle pulse.
// It fires only on the edge that enters RUNNING, it is never high for two
// consecutive cycles, and there is no back-pressure (the FSM must take it on
// the cycle it is seen).
module wash_panel_ctrl #(
   parameter int DEB_CYCLES  = 4,
   parameter int NUM_PROGS   = 4,
   parameter int BUZZ_CYCLES = 16,
   parameter int TICK_CYCLES = 1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       power,
   input  logic       btn_prog,
   input  logic       btn_start,
   input  logic       door_sensor,
   input  logic       program_done,
   input  logic       soap_warning,
   output logic [2:0] program_selection,
   output logic       start,
   output logic       door_lock,
   output logic       buzzer,
   output logic       busy,
   output logic [7:0] run_time,
   output logic [1:0] state_dbg
);

   typedef enum logic [1:0] {
      ST_OFF        = 2'd0,
      ST_SELECT     = 2'd1,
      ST_RUNNING    = 2'd2,
      ST_DONE_ALERT = 2'd3
   } state_t;

   localparam int CW = $clog2(DEB_CYCLES);
   localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
   localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
   // One counter serves both the 4-cycle error beep and the done alert.
   localparam int BMAX = (BUZZ_CYCLES > 4) ? BUZZ_CYCLES : 4;
   localparam int BW = $clog2(BMAX);
   localparam logic [BW-1:0] BUZZ_LAST = BW'(BUZZ_CYCLES - 1);
   localparam logic [BW-1:0] BEEP_LAST = BW'(3);
   localparam logic [2:0] SEL_LAST = 3'(NUM_PROGS - 1);

   // ---------------------------------------------------------------------
   // Button path, bit 0 = program button, bit 1 = start button
   // ---------------------------------------------------------------------
   logic [1:0]         raw_btn;
   logic [1:0]         sync1_q, sync2_q;
   logic [1:0]         deb_q, deb_d;
   logic [1:0]         deb_dly_q;
   logic [1:0]         press_q, press_d;
   logic [1:0][CW-1:0] deb_cnt_q, deb_cnt_d;

   assign raw_btn = {btn_start, btn_prog};

   // Debounce: count consecutive samples that disagree with the accepted
   // level; flip the level once the disagreement has lasted DEB_CYCLES.
   always_comb begin
      deb_d     = deb_q;
      deb_cnt_d = '0;
      for (int i = 0; i < 2; i++) begin
         if (sync2_q[i] != deb_q[i]) begin
            if (deb_cnt_q[i] == DEB_LAST) begin
               deb_d[i] = sync2_q[i];
            end else begin
               deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
            end
         end
      end
      // Press event is the registered rising edge of the debounced level.
      press_d = deb_q & ~deb_dly_q;
   end

   // Synchronizers, debounce state and registered press events.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         deb_q     <= '0;
         deb_dly_q <= '0;
         press_q   <= '0;
         deb_cnt_q <= '0;
      end else begin
         sync1_q   <= raw_btn;
         sync2_q   <= sync1_q;
         deb_q     <= deb_d;
         deb_dly_q <= deb_q;
         press_q   <= press_d;
         deb_cnt_q <= deb_cnt_d;
      end
   end

   logic prog_ev, start_ev;
   assign prog_ev  = press_q[0];
   assign start_ev = press_q[1];

   // ---------------------------------------------------------------------
   // Panel FSM with registered outputs
   // ---------------------------------------------------------------------
   state_t          state_q, state_d;
   logic [2:0]      sel_q, sel_d;
   logic            start_q, start_d;
   logic            lock_q, lock_d;
   logic            buzz_q, buzz_d;
   logic            busy_q, busy_d;
   logic [7:0]      rt_q, rt_d;
   logic [TW-1:0]   tick_q, tick_d;
   logic [BW-1:0]   bcnt_q, bcnt_d;
   logic            soap_act_q, soap_act_d;

   // Next-state and next-output logic; power loss overrides every state.
   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      start_d    = 1'b0;
      lock_d     = lock_q;
      buzz_d     = buzz_q;
      busy_d     = busy_q;
      rt_d       = rt_q;
      tick_d     = tick_q;
      bcnt_d     = bcnt_q;
      soap_act_d = 1'b0;

      if (!power) begin
         state_d = ST_OFF;
         sel_d   = '0;
         lock_d  = 1'b0;
         buzz_d  = 1'b0;
         busy_d  = 1'b0;
         rt_d    = '0;
         tick_d  = '0;
         bcnt_d  = '0;
      end else begin
         case (state_q)
            ST_OFF: begin
               state_d = ST_SELECT;
            end

            ST_SELECT: begin
               lock_d = 1'b0;
               busy_d = 1'b0;
               // Remaining error-beep cycles, if any.
               buzz_d = (bcnt_q != '0);
               if (bcnt_q != '0) begin
                  bcnt_d = bcnt_q - 1'b1;
               end
               // Start outranks a simultaneous program press.
               if (start_ev) begin
                  if (door_sensor) begin
                     state_d = ST_RUNNING;
                     start_d = 1'b1;
                     lock_d  = 1'b1;
                     busy_d  = 1'b1;
                     buzz_d  = 1'b0;
                     bcnt_d  = '0;
                     rt_d    = '0;
                     tick_d  = '0;
                  end else begin
                     buzz_d = 1'b1;
                     bcnt_d = BEEP_LAST;
                  end
               end else if (prog_ev) begin
                  sel_d = (sel_q == SEL_LAST) ? 3'd0 : sel_q + 3'd1;
               end
            end

            ST_RUNNING: begin
               lock_d = 1'b1;
               busy_d = 1'b1;
               if (tick_q == TICK_LAST) begin
                  tick_d = '0;
                  if (rt_q != 8'hFF) begin
                     rt_d = rt_q + 8'd1;
                  end
               end else begin
                  tick_d = tick_q + 1'b1;
               end
               // Open door is a fault and beats the soap toggle.
               if (!door_sensor) begin
                  buzz_d = 1'b1;
               end else if (soap_warning) begin
                  buzz_d = soap_act_q ? ~buzz_q : 1'b1;
               end else begin
                  buzz_d = 1'b0;
               end
               soap_act_d = door_sensor & soap_warning;
               if (program_done) begin
                  state_d = ST_DONE_ALERT;
                  lock_d  = 1'b0;
                  busy_d  = 1'b0;
                  buzz_d  = 1'b1;
                  bcnt_d  = BUZZ_LAST;
               end
            end

            ST_DONE_ALERT: begin
               lock_d = 1'b0;
               busy_d = 1'b0;
               // A press only silences the alert; it is not acted on.
               if (prog_ev || start_ev) begin
                  state_d = ST_SELECT;
                  buzz_d  = 1'b0;
                  bcnt_d  = '0;
               end else if (bcnt_q == '0) begin
                  state_d = ST_SELECT;
                  buzz_d  = 1'b0;
               end else begin
                  buzz_d = 1'b1;
                  bcnt_d = bcnt_q - 1'b1;
               end
            end

            default: begin
               state_d = ST_OFF;
            end
         endcase
      end
   end

   // Panel state and output registers; reset drops the door lock at once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_OFF;
         sel_q      <= '0;
         start_q    <= 1'b0;
         lock_q     <= 1'b0;
         buzz_q     <= 1'b0;
         busy_q     <= 1'b0;
         rt_q       <= '0;
         tick_q     <= '0;
         bcnt_q     <= '0;
         soap_act_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         start_q    <= start_d;
         lock_q     <= lock_d;
         buzz_q     <= buzz_d;
         busy_q     <= busy_d;
         rt_q       <= rt_d;
         tick_q     <= tick_d;
         bcnt_q     <= bcnt_d;
         soap_act_q <= soap_act_d;
      end
   end

   assign program_selection = sel_q;
   assign start             = start_q;
   assign door_lock         = lock_q;
   assign buzzer            = buzz_q;
   assign busy              = busy_q;
   assign run_time          = rt_q;
   assign state_dbg         = state_q;

endmodule

// File: tb/tb_wash_panel_ctrl.sv
// Testbench for wash_panel_ctrl: scenario tasks with inline checks against
// a spec-level model (selection arithmetic, run-time from elapsed cycles).
module tb_wash_panel_ctrl;

   localparam int DEB  = 4;
   localparam int NP   = 4;
   localparam int BUZZ = 16;
   localparam int TICK = 10;
   // Debug state codes exposed by the design.
   localparam logic [1:0] S_OFF = 2'd0;
   localparam logic [1:0] S_SEL = 2'd1;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       power = 1'b0;
   logic       btn_prog = 1'b0;
   logic       btn_start = 1'b0;
   logic       door_sensor = 1'b1;
   logic       program_done = 1'b0;
   logic       soap_warning = 1'b0;
   logic [2:0] program_selection;
   logic       start;
   logic       door_lock;
   logic       buzzer;
   logic       busy;
   logic [7:0] run_time;
   logic [1:0] state_dbg;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int m_sel    = 0;
   int run_start = 0;
   logic [2:0] exp_q[$];

   wash_panel_ctrl #(
      .DEB_CYCLES(DEB), .NUM_PROGS(NP), .BUZZ_CYCLES(BUZZ), .TICK_CYCLES(TICK)
   ) dut (
      .clk(clk), .rst(rst), .power(power), .btn_prog(btn_prog),
      .btn_start(btn_start), .door_sensor(door_sensor),
      .program_done(program_done), .soap_warning(soap_warning),
      .program_selection(program_selection), .start(start),
      .door_lock(door_lock), .buzzer(buzzer), .busy(busy),
      .run_time(run_time), .state_dbg(state_dbg)
   );

   // Clock and edge counter.
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Watchdog.
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic steps(input int n);
      repeat (n) step();
   endtask

   task automatic press_prog(input int hold, input int gap);
      btn_prog = 1'b1;
      steps(hold);
      btn_prog = 1'b0;
      steps(gap);
   endtask

   // Starts a run with the door closed; returns with start already seen.
   task automatic begin_run();
      door_sensor = 1'b1;
      btn_start = 1'b1;
      steps(DEB + 4);
      run_start = cyc;
      n_checks++;
      if (start !== 1'b1) begin
         n_fail++;
         $display("FAIL begin_run_start: start=%b expected 1", start);
      end
      btn_start = 1'b0;
   endtask

   function automatic int exp_rt();
      int t;
      t = (cyc - run_start) / TICK;
      return (t > 255) ? 255 : t;
   endfunction

   // ---------------- scenarios ----------------
   task automatic test_reset();
      steps(3);
      n_checks++;
      if ({program_selection, start, door_lock, buzzer, busy, run_time, state_dbg} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: sel=%0d start=%b lock=%b buzz=%b busy=%b rt=%0d st=%0d expected all 0",
                  program_selection, start, door_lock, buzzer, busy, run_time, state_dbg);
      end
      power = 1'b1;
      steps(2);
      n_checks++;
      if (state_dbg !== S_OFF) begin
         n_fail++;
         $display("FAIL reset_hold: state=%0d expected %0d", state_dbg, S_OFF);
      end
      rst = 1'b1;
      step();
      n_checks++;
      if (state_dbg !== S_SEL || program_selection !== 3'd0) begin
         n_fail++;
         $display("FAIL power_on_select: state=%0d sel=%0d expected state %0d sel 0",
                  state_dbg, program_selection, S_SEL);
      end
   endtask

   task automatic test_prog_select();
      for (int i = 0; i < 4; i++) begin
         m_sel = (m_sel + 1) % NP;
         exp_q.push_back(3'(m_sel));
         press_prog(10, 10);
         n_checks++;
         if (program_selection !== exp_q[0]) begin
            n_fail++;
            $display("FAIL prog_fixed_press%0d: sel=%0d expected %0d", i, program_selection, exp_q[0]);
         end
         void'(exp_q.pop_front());
      end
      for (int i = 0; i < 6; i++) begin
         m_sel = (m_sel + 1) % NP;
         exp_q.push_back(3'(m_sel));
         press_prog($urandom_range(DEB, 12), $urandom_range(DEB + 4, 12));
         n_checks++;
         if (program_selection !== exp_q[0]) begin
            n_fail++;
            $display("FAIL prog_rand_press%0d: sel=%0d expected %0d", i, program_selection, exp_q[0]);
         end
         void'(exp_q.pop_front());
      end
   endtask

   task automatic test_glitch();
      for (int i = 0; i < 3; i++) begin
         press_prog($urandom_range(1, DEB - 1), 12);
         n_checks++;
         if (program_selection !== 3'(m_sel)) begin
            n_fail++;
            $display("FAIL glitch%0d: sel=%0d expected %0d", i, program_selection, m_sel);
         end
      end
      // Exactly DEB cycles is the shortest accepted press.
      press_prog(DEB, 12);
      m_sel = (m_sel + 1) % NP;
      n_checks++;
      if (program_selection !== 3'(m_sel)) begin
         n_fail++;
         $display("FAIL min_width_press: sel=%0d expected %0d", program_selection, m_sel);
      end
   endtask

   task automatic test_start_door_open();
      int start_hi, buzz_hi, first_buzz;
      start_hi = 0; buzz_hi = 0; first_buzz = -1;
      door_sensor = 1'b0;
      btn_start = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         if (start) start_hi++;
         if (buzzer) begin
            buzz_hi++;
            if (first_buzz < 0) first_buzz = i;
         end
      end
      btn_start = 1'b0;
      steps(10);
      door_sensor = 1'b1;
      n_checks++;
      if (start_hi !== 0) begin
         n_fail++;
         $display("FAIL door_open_no_start: start cycles=%0d expected 0", start_hi);
      end
      n_checks++;
      if (buzz_hi !== 4 || first_buzz !== DEB + 3) begin
         n_fail++;
         $display("FAIL door_open_beep: buzzer cycles=%0d first=%0d expected 4 at %0d",
                  buzz_hi, first_buzz, DEB + 3);
      end
      n_checks++;
      if (state_dbg !== S_SEL || door_lock !== 1'b0 || program_selection !== 3'(m_sel)) begin
         n_fail++;
         $display("FAIL door_open_state: state=%0d lock=%b sel=%0d expected %0d 0 %0d",
                  state_dbg, door_lock, program_selection, S_SEL, m_sel);
      end
   endtask

   // Start and program pressed together: start wins, selection kept.
   task automatic test_start_timing();
      door_sensor = 1'b1;
      btn_start = 1'b1;
      btn_prog  = 1'b1;
      for (int i = 0; i <= 10; i++) begin
         step();
         if (i == DEB + 3) run_start = cyc;
         n_checks++;
         if (start !== (i == DEB + 3) || door_lock !== (i >= DEB + 3) || busy !== (i >= DEB + 3)) begin
            n_fail++;
            $display("FAIL start_timing_edge%0d: start=%b lock=%b busy=%b expected %b %b %b",
                     i, start, door_lock, busy, i == DEB + 3, i >= DEB + 3, i >= DEB + 3);
         end
      end
      btn_start = 1'b0;
      btn_prog  = 1'b0;
      steps(6);
      n_checks++;
      if (program_selection !== 3'(m_sel)) begin
         n_fail++;
         $display("FAIL start_wins_sel: sel=%0d expected %0d", program_selection, m_sel);
      end
   endtask

   task automatic test_run_time();
      int e;
      for (int i = 0; i < 4; i++) begin
         steps($urandom_range(50, 400));
         e = exp_rt();
         n_checks++;
         if (run_time !== 8'(e) || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL run_time_sample%0d: rt=%0d busy=%b expected %0d 1", i, run_time, busy, e);
         end
      end
      // Program button is ignored while running.
      press_prog(8, 8);
      n_checks++;
      if (program_selection !== 3'(m_sel)) begin
         n_fail++;
         $display("FAIL sel_frozen_run: sel=%0d expected %0d", program_selection, m_sel);
      end
      if (cyc - run_start < 3000) steps(3000 - (cyc - run_start));
      n_checks++;
      if (run_time !== 8'd255) begin
         n_fail++;
         $display("FAIL run_time_saturate: rt=%0d expected 255", run_time);
      end
   endtask

   task automatic test_soap_and_fault();
      soap_warning = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         n_checks++;
         if (buzzer !== ((i % 2) == 0)) begin
            n_fail++;
            $display("FAIL soap_toggle%0d: buzzer=%b expected %b", i, buzzer, (i % 2) == 0);
         end
      end
      door_sensor = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         n_checks++;
         if (buzzer !== 1'b1) begin
            n_fail++;
            $display("FAIL door_fault%0d: buzzer=%b expected 1", i, buzzer);
         end
      end
      door_sensor  = 1'b1;
      soap_warning = 1'b0;
      step();
      n_checks++;
      if (buzzer !== 1'b0 || door_lock !== 1'b1) begin
         n_fail++;
         $display("FAIL buzzer_quiet: buzzer=%b lock=%b expected 0 1", buzzer, door_lock);
      end
   endtask

   task automatic test_done_alert();
      int hi, e;
      program_done = 1'b1;
      step();
      program_done = 1'b0;
      e = exp_rt();
      n_checks++;
      if (door_lock !== 1'b0 || busy !== 1'b0 || buzzer !== 1'b1 || run_time !== 8'(e)) begin
         n_fail++;
         $display("FAIL done_entry: lock=%b busy=%b buzz=%b rt=%0d expected 0 0 1 %0d",
                  door_lock, busy, buzzer, run_time, e);
      end
      hi = 1;
      for (int i = 0; i < 40; i++) begin
         step();
         if (!buzzer) break;
         hi++;
      end
      n_checks++;
      if (hi !== BUZZ || state_dbg !== S_SEL) begin
         n_fail++;
         $display("FAIL done_alert_len: buzzer cycles=%0d state=%0d expected %0d %0d",
                  hi, state_dbg, BUZZ, S_SEL);
      end
      // A stray program_done in SELECT does nothing.
      program_done = 1'b1;
      step();
      program_done = 1'b0;
      steps(2);
      n_checks++;
      if (state_dbg !== S_SEL || buzzer !== 1'b0 || run_time !== 8'(e)) begin
         n_fail++;
         $display("FAIL done_ignored: state=%0d buzz=%b rt=%0d expected %0d 0 %0d",
                  state_dbg, buzzer, run_time, S_SEL, e);
      end
   endtask

   task automatic test_alert_abort();
      int hi, e;
      begin_run();
      steps($urandom_range(20, 200));
      program_done = 1'b1;
      step();
      program_done = 1'b0;
      e = exp_rt();
      n_checks++;
      if (run_time !== 8'(e)) begin
         n_fail++;
         $display("FAIL short_run_time: rt=%0d expected %0d", run_time, e);
      end
      hi = buzzer ? 1 : 0;
      for (int i = 0; i < 2; i++) begin
         step();
         if (buzzer) hi++;
      end
      btn_prog = 1'b1;
      for (int i = 0; i < 17; i++) begin
         step();
         if (i == 8) btn_prog = 1'b0;
         if (buzzer) hi++;
      end
      n_checks++;
      if (hi !== DEB + 6) begin
         n_fail++;
         $display("FAIL alert_abort_len: buzzer cycles=%0d expected %0d", hi, DEB + 6);
      end
      steps(10);
      n_checks++;
      if (state_dbg !== S_SEL || program_selection !== 3'(m_sel) || run_time !== 8'(e)) begin
         n_fail++;
         $display("FAIL alert_abort_state: state=%0d sel=%0d rt=%0d expected %0d %0d %0d",
                  state_dbg, program_selection, run_time, S_SEL, m_sel, e);
      end
   endtask

   task automatic test_power_loss();
      press_prog(DEB + 2, 10);
      m_sel = (m_sel + 1) % NP;
      begin_run();
      steps($urandom_range(15, 60));
      power = 1'b0;
      step();
      n_checks++;
      if ({program_selection, start, door_lock, buzzer, busy, run_time, state_dbg} !== '0) begin
         n_fail++;
         $display("FAIL power_loss: sel=%0d start=%b lock=%b buzz=%b busy=%b rt=%0d st=%0d expected all 0",
                  program_selection, start, door_lock, buzzer, busy, run_time, state_dbg);
      end
      power = 1'b1;
      step();
      m_sel = 0;
      n_checks++;
      if (state_dbg !== S_SEL || program_selection !== 3'd0 || run_time !== 8'd0) begin
         n_fail++;
         $display("FAIL power_recover: state=%0d sel=%0d rt=%0d expected %0d 0 0",
                  state_dbg, program_selection, run_time, S_SEL);
      end
   endtask

   task automatic test_reset_mid_run();
      press_prog(DEB + 2, 10);
      m_sel = (m_sel + 1) % NP;
      begin_run();
      steps($urandom_range(15, 60));
      @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      n_checks++;
      if ({program_selection, start, door_lock, buzzer, busy, run_time, state_dbg} !== '0) begin
         n_fail++;
         $display("FAIL async_reset: sel=%0d lock=%b buzz=%b busy=%b rt=%0d st=%0d expected all 0",
                  program_selection, door_lock, buzzer, busy, run_time, state_dbg);
      end
      steps(2);
      rst = 1'b1;
      step();
      m_sel = 0;
      n_checks++;
      if (state_dbg !== S_SEL || program_selection !== 3'd0 || run_time !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_recover: state=%0d sel=%0d rt=%0d expected %0d 0 0",
                  state_dbg, program_selection, run_time, S_SEL);
      end
      press_prog(DEB + 2, 10);
      m_sel = (m_sel + 1) % NP;
      n_checks++;
      if (program_selection !== 3'(m_sel)) begin
         n_fail++;
         $display("FAIL select_after_reset: sel=%0d expected %0d", program_selection, m_sel);
      end
   endtask

   initial begin
      test_reset();
      test_prog_select();
      test_glitch();
      test_start_door_open();
      test_start_timing();
      test_run_time();
      test_soap_and_fault();
      test_done_alert();
      test_alert_abort();
      test_power_loss();
      test_reset_mid_run();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/wash_panel_ctrl.md
Name: wash_panel_ctrl

Overview:
- Front-panel controller on the operator side of the washer control interface.
- Debounces the raw program and start buttons, holds the program selection, and issues the one-cycle start request to the washer FSM.
- Locks the door while a program runs, counts run time, and drives the buzzer from the FSM's program_done and soap_warning status.

Parameters:
DEB_CYCLES, 4, consecutive stable synchronized samples required to accept a button level change (>=2)
NUM_PROGS, 4, number of selectable programs; selection wraps at NUM_PROGS-1 (<=8)
BUZZ_CYCLES, 16, done-alert buzzer duration in clocks
TICK_CYCLES, 1000, clocks per run-time tick

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
power  in  1  mains power switch level
btn_prog  in  1  raw program-select button, active-high, asynchronous
btn_start  in  1  raw start button, active-high, asynchronous
door_sensor  in  1  1 = door closed
program_done  in  1  one-cycle pulse from washer FSM at end of program
soap_warning  in  1  level from washer FSM, waiting for soap
program_selection  out  3  program code to washer FSM
start  out  1  one-cycle start request to washer FSM
door_lock  out  1  door lock solenoid
buzzer  out  1  buzzer drive
busy  out  1  high in RUNNING
run_time  out  8  ticks elapsed in current/last run, saturating

Behaviour:
- Reset (rst=0, async): state OFF; all outputs 0; debounce counters, synchronizers and tick counters cleared. Release takes effect at the next clk edge.
- Button path (each button independently):
  - 2-flop synchronizer feeds a counter.
  - The counter increments while the synchronized value differs from the debounced level. It clears to 0 when they match.
  - When the count reaches DEB_CYCLES-1 with values still differing, the debounced level flips on the next edge.
  - A press event is a debounced 0->1 flip, one cycle wide.
  - Glitches shorter than DEB_CYCLES cycles produce no event.
  - A raw press first sampled at edge N produces its event at edge N+DEB_CYCLES+2. Any registered action appears at edge N+DEB_CYCLES+3.
- OFF: all outputs 0, program_selection 0, run_time 0. power=1 -> SELECT.
- SELECT:
  - prog event: program_selection <= (sel+1) mod NUM_PROGS.
  - start event with door_sensor=1: start=1 for exactly one cycle, door_lock=1, busy=1, run_time <= 0, go to RUNNING. All take effect on the same edge.
  - start event with door_sensor=0: no start. buzzer=1 for 4 cycles (error beep). Stay in SELECT.
  - prog and start events in the same cycle: start wins; selection is not incremented.
- RUNNING:
  - program_selection frozen; prog and start events ignored; door_lock=1; busy=1.
  - Tick counter counts to TICK_CYCLES-1 and wraps. run_time increments on each wrap and saturates at 255.
  - Buzzer priority: door_sensor=0 gives buzzer=1 continuously (fault). Otherwise soap_warning=1 toggles buzzer every clock, starting at 1. Otherwise buzzer=0.
  - program_done=1 -> DONE_ALERT on the next edge.
- DONE_ALERT:
  - door_lock=0; busy=0; run_time holds its final value; buzzer=1 for BUZZ_CYCLES clocks, then SELECT.
  - Any press event ends the alert early (buzzer=0 next edge) and returns to SELECT. That press is consumed, not acted on.
- power=0 in any state: OFF on the next edge; all outputs 0 on that edge; selection and run_time cleared.
- program_done outside RUNNING is ignored.
- Reset mid-run behaves exactly as power loss, with door_lock dropping asynchronously.
- start is never high for two consecutive cycles.
- program_selection never changes while busy=1.

Test Plan:
- Reset, power=1, press btn_prog 3 times (each 10 clk high, 10 low), DEB_CYCLES=4 -> program_selection 0->1->2->3; a 4th press -> 0.
- btn_prog glitch high 3 clk -> no selection change; btn_start held from edge N with door_sensor=1 -> start=1 only at edge N+7; door_lock=1, busy=1 from the same edge.
- start press with door_sensor=0 -> start stays 0; buzzer high exactly 4 cycles; state remains SELECT.
- RUNNING with TICK_CYCLES=10 for 3000 clk -> run_time saturates at 255. Assert soap_warning -> buzzer alternates 1,0,1,... Drop door_sensor -> buzzer steady 1.
- program_done pulse in RUNNING -> door_lock=0 next edge; buzzer high 16 cycles, then SELECT. Repeat with a btn_prog press mid-alert -> alert ends; selection unchanged.
- power=0 mid-run, and separately rst=0 mid-run -> all outputs 0 (rst asynchronously); after recovery, program_selection=0 and run_time=0.
